// File: rtl/ledstring_fb.sv
// Framebuffer for a WS2812 LED string: stores N_LEDS pixels and streams them
// one word at a time to a ws2812_tx serializer, followed by a latch gap.
module ledstring_fb #(
  parameter int N_LEDS      = 8,
  parameter int RESET_CYC   = 3000,
  parameter int REFRESH_CYC = 12_000_000,
  parameter int RGB_ORDER   = 0,
  localparam int AW         = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  input  logic          refresh,
  input  logic [2:0]    brightness,
  output logic          tx_start,
  output logic [23:0]   tx_data,
  input  logic          tx_bsy,
  output logic          frame_busy
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_SEND  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_LATCH = 3'd4;

  localparam logic [AW:0]   NUM_LEDS = (AW + 1)'(N_LEDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_LEDS - 1);
  localparam logic [31:0]   LAT_LAST = (RESET_CYC > 0) ? 32'(RESET_CYC - 1) : 32'd0;
  localparam logic [31:0]   TMR_LAST = (REFRESH_CYC > 0) ? 32'(REFRESH_CYC - 1) : 32'd0;

  logic [23:0]   fb_r [0:(2**AW)-1];
  logic [2:0]    state_r, state_s;
  logic [AW-1:0] idx_r, idx_s;
  logic          tx_start_r, tx_start_s;
  logic [23:0]   tx_data_r, tx_data_s;
  logic          frame_busy_r, frame_busy_s;
  logic [31:0]   lat_cnt_r, lat_cnt_s;
  logic          pend_r, pend_s;
  logic [31:0]   timer_r, timer_s;
  logic          timer_hit_s;
  logic          req_s;
  logic          start_s;
  logic [23:0]   pix_s;
  logic [23:0]   ord_s;
  logic [23:0]   fmt_s;

  // Pixel storage; deliberately not reset, and a write never reaches past N_LEDS.
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < NUM_LEDS)) begin
      fb_r[wr_addr] <= wr_data;
    end
  end

  // Auto-refresh timer, free-running regardless of the frame state.
  always_comb begin
    if (REFRESH_CYC > 0) begin
      timer_hit_s = (timer_r == TMR_LAST);
      timer_s     = timer_hit_s ? 32'd0 : timer_r + 32'd1;
    end else begin
      timer_hit_s = 1'b0;
      timer_s     = 32'd0;
    end
  end

  // Channel reorder and brightness shift of the pixel at the current index.
  always_comb begin
    pix_s = fb_r[idx_r];
    if (RGB_ORDER == 1) begin
      ord_s = pix_s;
    end else begin
      ord_s = {pix_s[15:8], pix_s[23:16], pix_s[7:0]};
    end
    fmt_s = {ord_s[23:16] >> brightness, ord_s[15:8] >> brightness, ord_s[7:0] >> brightness};
  end

  // Frame sequencer next-state logic, including the single pending-request slot.
  always_comb begin
    req_s        = refresh | timer_hit_s;
    start_s      = (state_r == ST_IDLE) && (pend_r || req_s);
    state_s      = state_r;
    idx_s        = idx_r;
    tx_start_s   = tx_start_r;
    tx_data_s    = tx_data_r;
    frame_busy_s = frame_busy_r;
    lat_cnt_s    = lat_cnt_r;

    // A request merges into the slot; starting a frame consumes it.
    if (start_s) begin
      pend_s = 1'b0;
    end else if (req_s) begin
      pend_s = 1'b1;
    end else begin
      pend_s = pend_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_s      = ST_FETCH;
          idx_s        = {AW{1'b0}};
          frame_busy_s = 1'b1;
        end else begin
          tx_start_s = 1'b0;
        end
      end
      ST_FETCH: begin
        state_s    = ST_SEND;
        tx_data_s  = fmt_s;
        tx_start_s = 1'b1;
      end
      ST_SEND: begin
        if (tx_bsy) begin
          state_s    = ST_WAIT;
          tx_start_s = 1'b0;
        end else begin
          tx_start_s = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!tx_bsy) begin
          if (idx_r == LAST_IDX) begin
            state_s   = ST_LATCH;
            lat_cnt_s = 32'd0;
          end else begin
            state_s = ST_FETCH;
            idx_s   = idx_r + AW'(1);
          end
        end else begin
          tx_start_s = 1'b0;
        end
      end
      ST_LATCH: begin
        if (lat_cnt_r == LAT_LAST) begin
          state_s      = ST_IDLE;
          frame_busy_s = 1'b0;
        end else begin
          lat_cnt_s = lat_cnt_r + 32'd1;
        end
      end
      default: begin
        state_s      = ST_IDLE;
        tx_start_s   = 1'b0;
        frame_busy_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      idx_r        <= {AW{1'b0}};
      tx_start_r   <= 1'b0;
      tx_data_r    <= 24'd0;
      frame_busy_r <= 1'b0;
      lat_cnt_r    <= 32'd0;
      pend_r       <= 1'b0;
      timer_r      <= 32'd0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      tx_start_r   <= tx_start_s;
      tx_data_r    <= tx_data_s;
      frame_busy_r <= frame_busy_s;
      lat_cnt_r    <= lat_cnt_s;
      pend_r       <= pend_s;
      timer_r      <= timer_s;
    end
  end

  assign tx_start   = tx_start_r;
  assign tx_data    = tx_data_r;
  assign frame_busy = frame_busy_r;

endmodule

// File: doc/ledstring_fb.md
LEDSTRING_FB -- requirements
Module: ledstring_fb

Interface
REQ-001 SHALL have parameter N_LEDS, default 8, number of LEDs in the string (>= 1).
REQ-002 SHALL have parameter RESET_CYC, default 3000, minimum idle cycles after a frame (latch gap, >50 us at 48 MHz).
REQ-003 SHALL have parameter REFRESH_CYC, default 12_000_000, cycles between automatic refresh starts; 0 = manual refresh only.
REQ-004 SHALL have parameter RGB_ORDER, default 0; 0 = tx_data is {G,R,B}, 1 = tx_data is {R,G,B}.
REQ-005 SHALL have port clk, input, 1, the only clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-007 SHALL have port wr_en, input, 1, framebuffer write strobe.
REQ-008 SHALL have port wr_addr, input, $clog2(N_LEDS) (min 1), LED index to write.
REQ-009 SHALL have port wr_data, input, 24, colour as {R[7:0],G[7:0],B[7:0]}.
REQ-010 SHALL have port refresh, input, 1, one-cycle request to send a frame.
REQ-011 SHALL have port brightness, input, 3, global right-shift applied to every channel (0 = full).
REQ-012 SHALL have port tx_start, output, 1, start request to the ws2812_tx serializer.
REQ-013 SHALL have port tx_data, output, 24, pixel word to the serializer.
REQ-014 SHALL have port tx_bsy, input, 1, serializer busy flag.
REQ-015 SHALL have port frame_busy, output, 1, high from frame start until the latch gap ends.

Function
REQ-016 SHALL store N_LEDS x 24-bit pixels; a write with wr_en=1 and wr_addr < N_LEDS updates the pixel on the next edge; wr_addr >= N_LEDS is ignored.
REQ-017 SHALL implement states IDLE, FETCH, SEND, WAIT_TX, LATCH.
REQ-018 IDLE -> FETCH when a refresh is pending; the pixel index resets to 0; frame_busy rises in the same cycle as FETCH is entered.
REQ-019 FETCH lasts exactly one cycle; it registers the pixel at the current index into tx_data, after channel reorder and brightness shift.
REQ-020 SEND: tx_start=1 and is held until tx_bsy is sampled 1, then -> WAIT_TX with tx_start=0 in the following cycle.
REQ-021 WAIT_TX: on tx_bsy=0, -> FETCH with index+1 if index < N_LEDS-1, otherwise -> LATCH.
REQ-022 LATCH: count RESET_CYC cycles with tx_start=0, then -> IDLE with frame_busy=0.
REQ-023 tx_data SHALL remain stable from FETCH exit until WAIT_TX exit.
REQ-024 Pending refresh is set by refresh=1 or by the auto timer reaching REFRESH_CYC-1 (then the timer wraps to 0); it is cleared on IDLE->FETCH; at most one request is held, and requests arriving while one is pending merge.
REQ-025 A refresh arriving during a frame SHALL be held pending and start a new frame right after LATCH; the running frame is never restarted.
REQ-026 A write to an index not yet fetched in the current frame is sent in that frame; a write to an already fetched index is sent in the next frame.
REQ-027 A write and a FETCH of the same index in one cycle SHALL send the old value.
REQ-028 Brightness SHALL apply per 8-bit channel as a logical right shift; brightness is sampled at FETCH.
REQ-029 The auto timer SHALL run in every state, independent of the FSM.

Reset
REQ-030 With rst=0 at an edge: state=IDLE, tx_start=0, tx_data=0, frame_busy=0, index=0, pending=0, auto timer=0.
REQ-031 Framebuffer contents SHALL NOT be reset; the bench writes every pixel before checking tx_data.
REQ-032 Reset mid-frame SHALL drop tx_start on the next edge and discard the pending request.

Verification
REQ-033 N_LEDS=3, REFRESH_CYC=0: write {R,G,B} 0x112233 to idx0, 0 to idx1 and idx2, pulse refresh, model tx_bsy high 2 cycles after tx_start -> three transfers, tx_data 0x221133, 0, 0; frame_busy low exactly RESET_CYC cycles after the last tx_bsy fall.
REQ-034 RGB_ORDER=1, brightness=2, pixel 0xFF8040 -> tx_data 0x3F2010.
REQ-035 refresh pulsed twice during a frame -> exactly one further frame starts on the cycle after LATCH ends.
REQ-036 Write idx2 while idx0 is in WAIT_TX -> new value sent this frame; write idx0 in the same situation -> old value sent, new value in the next frame.
REQ-037 REFRESH_CYC=100, no refresh input -> FETCH entered at cycles 100, 200, ... after reset, as long as each frame ends before the next timer expiry.
REQ-038 rst=0 asserted during SEND -> tx_start=0 and frame_busy=0 next cycle; no frame starts until a new request arrives.
